// File: rtl/exe_muldiv_ctrl.sv
// EXE-stage sequencer for MULT/MULTU/DIV/DIVU: pipelined multiply, 32-step
// restoring divide, pipeline stall while busy and a one-cycle HI/LO result pulse.
module exe_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        cancel_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DPREP = 3'd2;
  localparam logic [2:0] S_DITER = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int PIPE_D    = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int PIPE_LAST = PIPE_D - 1;
  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] prod_q [PIPE_D];
  logic [63:0] prod_d [PIPE_D];
  logic [63:0] rq_q, rq_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept;
  logic        mul_sx;
  logic [63:0] mul_ea, mul_eb, mul_full;
  logic [31:0] a_abs, b_abs;
  logic        sub_ok;
  logic [31:0] rem_sub;
  logic [63:0] step;
  logic [31:0] quot_fix, rem_fix;

  assign accept = start_i & ~cancel_i & ((state_q == S_IDLE) | (state_q == S_DONE));

  // 64-bit truncated product of correctly extended operands serves MULT and MULTU alike.
  always_comb begin
    mul_sx   = ~op_i[0];
    mul_ea   = {{32{mul_sx & src_a_i[31]}}, src_a_i};
    mul_eb   = {{32{mul_sx & src_b_i[31]}}, src_b_i};
    mul_full = mul_ea * mul_eb;
  end

  always_comb begin
    a_abs = (~op_q[0] & a_q[31]) ? (32'd0 - a_q) : a_q;
    b_abs = (~op_q[0] & b_q[31]) ? (32'd0 - b_q) : b_q;
  end

  // Restoring step on {remainder, quotient}; the shifted remainder needs 33 bits.
  always_comb begin
    sub_ok   = rq_q[63:31] >= {1'b0, dvs_q};
    rem_sub  = rq_q[62:31] - dvs_q;
    step     = sub_ok ? {rem_sub, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
    quot_fix = qneg_q ? (32'd0 - step[31:0])  : step[31:0];
    rem_fix  = rneg_q ? (32'd0 - step[63:32]) : step[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d[0] = prod_q[0];
    for (int i = 1; i < PIPE_D; i++) begin
      prod_d[i] = prod_q[i-1];
    end

    case (state_q)
      S_MUL: begin
        cnt_d = cnt_q - 5'd1;
        if (cancel_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd1) begin
          state_d = S_DONE;
          hi_d    = prod_q[PIPE_LAST][63:32];
          lo_d    = prod_q[PIPE_LAST][31:0];
        end
      end
      S_DPREP: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          rq_d    = {32'd0, a_abs};
          dvs_d   = b_abs;
          qneg_d  = ~op_q[0] & (a_q[31] ^ b_q[31]);
          rneg_d  = ~op_q[0] & a_q[31];
          cnt_d   = 5'd31;
          state_d = S_DITER;
        end
      end
      S_DITER: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          rq_d  = step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = S_DONE;
            hi_d    = rem_fix;
            lo_d    = quot_fix;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new operation may start from IDLE or straight out of DONE.
    if (accept) begin
      op_d = op_i;
      a_d  = src_a_i;
      b_d  = src_b_i;
      if (!op_i[1]) begin
        prod_d[0] = mul_full;
        if (MUL_LAT == 1) begin
          state_d = S_DONE;
          hi_d    = mul_full[63:32];
          lo_d    = mul_full[31:0];
        end else begin
          state_d = S_MUL;
          cnt_d   = MUL_CNT;
        end
      end else if (src_b_i == 32'd0) begin
        state_d = S_DONE;
        hi_d    = src_a_i;
        lo_d    = 32'hFFFF_FFFF;
      end else begin
        state_d = S_DPREP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rq_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      for (int i = 0; i < PIPE_D; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rq_q    <= rq_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      for (int i = 0; i < PIPE_D; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign busy_o  = (state_q == S_MUL) | (state_q == S_DPREP) | (state_q == S_DITER);
  assign done_o  = (state_q == S_DONE);
  assign stall_o = busy_o | accept;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Directed bench for exe_muldiv_ctrl: latency, results, cancel, reset and back-to-back.
module tb_exe_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        cancel_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  exe_muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .cancel_i (cancel_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle (cycle 0) and check stall/done up to cycle lat.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] eh, input logic [31:0] el,
                       input string tag);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
    tick();
    start_i = 1'b0; src_a_i = $urandom; src_b_i = $urandom;
    for (int c = 1; c <= lat; c++) begin
      #1;
      if (c < lat) begin
        if (stall_o !== 1'b1 || done_o !== 1'b0) begin
          chk({tag, "_stall_busy"}, {30'd0, stall_o, done_o}, 32'd2);
        end
      end else begin
        chk({tag, "_done"},  32'(done_o),  32'd1);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_hi"},    hi_o, eh);
        chk({tag, "_lo"},    lo_o, el);
        $display("[TB] %s op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h", tag, op, a, b, hi_o, lo_o);
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = 2'd0; src_a_i = '0; src_b_i = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    $display("[TB] reset checked");
    rst = 1'b0;
    tick();

    do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    do_op(2'd1, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_nega");
    do_op(2'd3, 32'd100, 32'd7, 34, 32'd2, 32'd14, "divu");
    do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, "div_negb");
    do_op(2'd3, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF, "divu_by0");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0");
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, "div_ovf");

    // Cancel on cycle 10 of a divide
    start_i = 1'b1; op_i = 2'd2; src_a_i = 32'd50; src_b_i = 32'd5;
    tick();
    start_i = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      #1; if (done_o) seen++;
      tick();
    end
    cancel_i = 1'b1;
    #1;
    chk("cancel_busy_c10", 32'(busy_o), 32'd1);
    tick();
    cancel_i = 1'b0;
    #1;
    chk("cancel_nodone", 32'(seen), 32'd0);
    chk("cancel_busy", 32'(busy_o), 32'd0);
    chk("cancel_done", 32'(done_o), 32'd0);
    chk("cancel_hi", hi_o, 32'd0);
    chk("cancel_lo", lo_o, 32'h8000_0000);
    $display("[TB] cancel at cycle 10 checked");
    do_op(2'd3, 32'd50, 32'd5, 34, 32'd0, 32'd10, "after_cancel");

    // Start together with cancel is not accepted
    start_i = 1'b1; cancel_i = 1'b1; op_i = 2'd1; src_a_i = 32'd9; src_b_i = 32'd9;
    #1;
    chk("startcancel_stall", 32'(stall_o), 32'd0);
    tick();
    start_i = 1'b0; cancel_i = 1'b0;
    #1;
    chk("startcancel_busy", 32'(busy_o), 32'd0);
    $display("[TB] start with cancel ignored");
    tick();

    // Reset on cycle 20 of a divide
    start_i = 1'b1; op_i = 2'd3; src_a_i = 32'd1000; src_b_i = 32'd3;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_stall", 32'(stall_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); if (done_o) seen++;
    end
    chk("midrst_nodone", 32'(seen), 32'd0);
    $display("[TB] reset mid-divide checked");

    // start_i while busy is ignored
    start_i = 1'b1; op_i = 2'd3; src_a_i = 32'd1000; src_b_i = 32'd3;
    tick();
    start_i = 1'b0; src_a_i = 32'd9; src_b_i = 32'd9;
    for (int c = 1; c < 5; c++) tick();
    start_i = 1'b1; op_i = 2'd1;
    #1;
    chk("busystart_stall", 32'(stall_o), 32'd1);
    chk("busystart_busy", 32'(busy_o), 32'd1);
    tick();
    start_i = 1'b0;
    seen = 0;
    for (int c = 6; c < 34; c++) begin
      #1; if (done_o) seen++;
      tick();
    end
    #1;
    chk("busystart_early", 32'(seen), 32'd0);
    chk("busystart_done", 32'(done_o), 32'd1);
    chk("busystart_hi", hi_o, 32'd1);
    chk("busystart_lo", lo_o, 32'd333);
    $display("[TB] start while busy ignored, hi=0x%08h lo=0x%08h", hi_o, lo_o);
    tick();

    // Cancel during DONE still pulses done_o
    start_i = 1'b1; op_i = 2'd0; src_a_i = 32'd4; src_b_i = 32'd5;
    tick();
    start_i = 1'b0;
    tick();
    cancel_i = 1'b1;
    #1;
    chk("donecancel_done", 32'(done_o), 32'd1);
    chk("donecancel_lo", lo_o, 32'd20);
    tick();
    cancel_i = 1'b0;
    #1;
    chk("donecancel_idle", {30'd0, busy_o, done_o}, 32'd0);
    $display("[TB] cancel in DONE checked");
    tick();

    // Back-to-back MULTU then DIVU accepted in DONE
    start_i = 1'b1; op_i = 2'd1; src_a_i = 32'd5; src_b_i = 32'd7;
    #1;
    chk("b2b_stall_c0", 32'(stall_o), 32'd1);
    tick();
    op_i = 2'd3; src_a_i = 32'd1000; src_b_i = 32'd7;
    #1;
    chk("b2b_stall_c1", 32'(stall_o), 32'd1);
    tick();
    #1;
    chk("b2b_done1", 32'(done_o), 32'd1);
    chk("b2b_hi1", hi_o, 32'd0);
    chk("b2b_lo1", lo_o, 32'd35);
    chk("b2b_stall_c2", 32'(stall_o), 32'd1);
    $display("[TB] b2b first multu hi=0x%08h lo=0x%08h", hi_o, lo_o);
    tick();
    start_i = 1'b0;
    seen = 0;
    for (int c = 3; c < 36; c++) begin
      #1; if (!stall_o || done_o) seen++;
      tick();
    end
    #1;
    chk("b2b_gap", 32'(seen), 32'd0);
    chk("b2b_done2", 32'(done_o), 32'd1);
    chk("b2b_hi2", hi_o, 32'd6);
    chk("b2b_lo2", lo_o, 32'd142);
    chk("b2b_stall_c36", 32'(stall_o), 32'd0);
    $display("[TB] b2b second divu hi=0x%08h lo=0x%08h", hi_o, lo_o);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_ctrl.md
Name: exe_muldiv_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EXE stage.
- Accepts one operation at a time from the ID/EXE register outputs and runs a pipelined multiply or a 32-iteration restoring divide.
- Stalls the pipeline while it works and delivers a one-cycle HI/LO result pulse that the HI/LO write path consumes.
- A cancel input aborts the operation when an older instruction raises an exception.

Parameters:
- MUL_LAT, 2, cycles from accepted start to done_o for multiplies; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  EXE holds a mul/div instruction this cycle.
- op_i  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- src_a_i  in  32  forwarded rs value (multiplicand / dividend); sampled with start_i.
- src_b_i  in  32  forwarded rt value (multiplier / divisor); sampled with start_i.
- cancel_i  in  1  flush from exception logic; aborts any operation in progress.
- stall_o  out  1  pipeline stall request to the hazard unit (IF_PCWr, IF_IDWr, ID_EXEWr held).
- busy_o  out  1  an operation is in flight.
- done_o  out  1  one-cycle pulse: hi_o/lo_o are valid.
- hi_o  out  32  product[63:32] or remainder.
- lo_o  out  32  product[31:0] or quotient.

Behaviour:
- Reset (rst=1 at a clock edge): state goes to IDLE; counters clear; busy_o=0, done_o=0, hi_o=0, lo_o=0. Reset has priority over everything, including mid-operation.
- States: IDLE, MUL, DPREP, DITER, DONE.
- Accept: start_i=1 and cancel_i=0 while the state is IDLE or DONE. Operands and op are latched at that edge.
- start_i in any other state is ignored; the hazard unit holds EXE, so the same instruction is re-presented later.
- Transitions from accept:
  - op_i[1]=0: go to MUL.
  - op_i[1]=1 and src_b_i≠0: go to DPREP.
  - op_i[1]=1 and src_b_i=0: go directly to DONE.
- MUL: down-counter loaded with MUL_LAT-1. The product is registered through the multiplier stages. Go to DONE when the counter reaches 0; with MUL_LAT=1, go to DONE on the next edge.
- MULT is a signed 32x32→64 multiply; MULTU is unsigned.
- DPREP (1 cycle): take absolute values for DIV (unsigned for DIVU) and record quotient sign (a[31]^b[31]) and remainder sign (a[31]). Clear the 64-bit partial-remainder register and load the iteration counter with 31.
- DITER: one restoring shift-subtract step per cycle, 32 cycles. Go to DONE after the step with counter=0.
- DONE (1 cycle): done_o=1; hi_o/lo_o hold the result with sign correction for DIV.
  - Result outputs are registered and stay stable until the next DONE entry.
  - done_o is 0 in every other state.
- Latency from the accepting edge (cycle 0) to done_o=1:
  - multiply: cycle MUL_LAT.
  - divide: cycle 34.
  - divide by zero: cycle 1.
- Divide by zero result: HI=src_a_i, LO=32'hFFFFFFFF for both DIV and DIVU. No exception is raised.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (32-bit wrap of the magnitude).
- Remainder sign follows the dividend; quotient truncates toward zero.
- busy_o = 1 in MUL, DPREP and DITER.
- stall_o (combinational) = busy_o OR (start_i AND state∈{IDLE,DONE} AND NOT cancel_i).
  - stall_o is 0 during DONE unless a new start is accepted, so the instruction advances with its result in the same cycle.
- cancel_i=1 in MUL, DPREP or DITER: go to IDLE at the next edge; done_o is never asserted for that operation and hi_o/lo_o are unchanged.
- cancel_i=1 in DONE: done_o still pulses this cycle (the HI/LO write is gated downstream by the exception logic), then go to IDLE.
- cancel_i=1 together with start_i: no accept.
- Back-to-back: start_i accepted in DONE begins the next operation; done_o for the first operation is still asserted in that DONE cycle.

Test Plan:
- MULT, MUL_LAT=2, a=0xFFFFFFFE (-2), b=3 → stall_o high on cycles 0-1; done_o on cycle 2 with HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 → done_o on cycle 34, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=100, b=7 → LO=14, HI=2. stall_o high on cycles 0-33 and low on cycle 34.
- DIVU a=0x12345678, b=0 → done_o on cycle 1, HI=0x12345678, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV started, cancel_i pulsed on cycle 10 → state IDLE on cycle 11; busy_o=0; no done_o ever; hi_o/lo_o keep their prior values. A new start on cycle 11 is accepted normally.
- rst asserted on cycle 20 of a divide → next cycle all outputs 0 and IDLE. start_i while busy (cycle 5) → ignored; the result matches the original operands.
- Back-to-back MULTU then DIVU, with the second start_i held during DONE → first done_o on cycle MUL_LAT, second done_o 34 cycles later. Both results correct; no cycle without stall_o between accepts other than the DONE cycle.
